word_serializer: RTL

Parallel-in, chunked-serial-out unload stage for wide datapath words. Captures a WIDTH-bit word on a `load` strobe, the same capture contract the team's load-enable registers use. Emits the word as WIDTH/CHUNK beats over a valid/ready stream. Sits between a register-file or result register and a narrow output bus, such as a debug/UART bridge or a memory write port.

---
 rtl/word_serializer_pkg.sv | 20 ++
 rtl/word_serializer_if.sv | 23 ++
 rtl/word_serializer_shift_reg.sv | 45 ++++
 rtl/word_serializer.sv | 98 +++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and elaboration helpers for the word serializer unload stage.
package word_serializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Beat counter width; a single-beat word still gets a 1-bit counter.
  function automatic int cnt_width(input int width, input int chunk);
    int beats;
    beats = width / chunk;
    if (beats > 1) begin
      cnt_width = $clog2(beats);
    end else begin
      cnt_width = 1;
    end
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Load/stream bundle between a word source, the serializer and a narrow sink.
interface word_serializer_if #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
);
  logic             load;
  logic [WIDTH-1:0] d;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [CHUNK-1:0] out_data;
  logic             out_last;

  modport master (
    output load, d, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  load, d, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/word_serializer_shift_reg.sv
// Chunk-wide shift register: parallel load, shift toward the output end, sync clear.
module word_shift_reg #(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [CHUNK-1:0] chunk_out
);

  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] shifted_s;

  // Vacated bits fill with zero, so a fully drained register reads as zero.
  generate
    if (WIDTH == CHUNK) begin : g_single
      assign shifted_s = {WIDTH{1'b0}};
      assign chunk_out = sh_r;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted_s = {sh_r[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
      assign chunk_out = sh_r[WIDTH-1 -: CHUNK];
    end else begin : g_lsb
      assign shifted_s = {{CHUNK{1'b0}}, sh_r[WIDTH-1:CHUNK]};
      assign chunk_out = sh_r[CHUNK-1:0];
    end
  endgenerate

  // Clear dominates load, load dominates shift.
  always_ff @(posedge clk) begin
    if (clr) begin
      sh_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sh_r <= d;
    end else if (shift) begin
      sh_r <= shifted_s;
    end else begin
      sh_r <= sh_r;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Captures a wide word on load and unloads it as WIDTH/CHUNK beats over valid/ready.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic clk,
  input  logic rst,
  word_serializer_if.slave bus
);

  localparam int BEATS = WIDTH / CHUNK;
  localparam int CW    = cnt_width(WIDTH, CHUNK);

  localparam logic [0:0]    IDLE     = ST_IDLE;
  localparam logic [0:0]    SEND     = ST_SEND;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $error("word_serializer: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  logic [0:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic             hs_s;
  logic             last_s;
  logic             in_ready_s;
  logic             load_acc_s;
  logic             shift_s;
  logic [CHUNK-1:0] chunk_s;

  // Handshake decode; in_ready deliberately looks through out_ready so the
  // next word can be taken on the same edge the last beat leaves.
  always_comb begin
    last_s     = (state_r == SEND) && (cnt_r == LAST_CNT);
    hs_s       = (state_r == SEND) && bus.out_ready;
    in_ready_s = !rst && ((state_r == IDLE) || (hs_s && last_s));
    load_acc_s = bus.load && in_ready_s;
    shift_s    = hs_s && !load_acc_s;
  end

  // Control FSM and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else if (load_acc_s) begin
      state_r <= SEND;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
          cnt_r   <= cnt_r;
        end
        SEND: begin
          if (hs_s && last_s) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
          end else if (hs_s) begin
            state_r <= SEND;
            cnt_r   <= cnt_r + CW'(1);
          end else begin
            state_r <= SEND;
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  word_shift_reg #(
    .WIDTH    (WIDTH),
    .CHUNK    (CHUNK),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .clr      (rst),
    .load     (load_acc_s),
    .shift    (shift_s),
    .d        (bus.d),
    .chunk_out(chunk_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == SEND);
  assign bus.out_last  = last_s;
  assign bus.out_data  = chunk_s;

endmodule
